// File: rtl/aidan_mcnay_div_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : aidan_mcnay_div_arbiter_pkg
// Brief  : Shared state encodings and requester ids for the divider arbiter.
// Rev    : 1.0
// ============================================================================
package aidan_mcnay_div_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_REQ  = 2'd1,
        GRANT_RESP = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/aidan_mcnay_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module : aidan_mcnay_rr_pick2
// Brief  : Combinational 2-way round-robin picker; prio breaks ties.
// Rev    : 1.0
// ============================================================================
module aidan_mcnay_rr_pick2
    import aidan_mcnay_div_arbiter_pkg::*;
(
    input  logic val0,
    input  logic val1,
    input  logic prio,
    output logic any,
    output logic winner
);

    always_comb begin
        any    = val0 | val1;
        winner = (val0 && val1) ? prio : (val1 ? REQ1 : REQ0);
    end

endmodule
`default_nettype wire

// File: rtl/aidan_mcnay_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module : aidan_mcnay_div_arbiter
// Brief  : Round-robin arbiter sharing one iterative divider between two users.
// Rev    : 1.0
// ============================================================================
module aidan_mcnay_div_arbiter
    import aidan_mcnay_div_arbiter_pkg::*;
#(
    parameter int nbits = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_istream_val,
    output logic             req0_istream_rdy,
    input  logic [nbits-1:0] req0_dividend,
    input  logic [nbits-1:0] req0_divisor,
    output logic             req0_ostream_val,
    input  logic             req0_ostream_rdy,
    output logic [nbits-1:0] req0_result,

    input  logic             req1_istream_val,
    output logic             req1_istream_rdy,
    input  logic [nbits-1:0] req1_dividend,
    input  logic [nbits-1:0] req1_divisor,
    output logic             req1_ostream_val,
    input  logic             req1_ostream_rdy,
    output logic [nbits-1:0] req1_result,

    output logic             div_istream_val,
    input  logic             div_istream_rdy,
    output logic [nbits-1:0] div_dividend,
    output logic [nbits-1:0] div_divisor,
    input  logic             div_ostream_val,
    output logic             div_ostream_rdy,
    input  logic [nbits-1:0] div_result,

    output logic             grant_id,
    output logic             busy
);

    state_t r_state;
    logic   r_grant_id;
    logic   r_prio;

    logic   w_any;
    logic   w_winner;
    logic   w_g_ival;
    logic   w_g_ordy;

    aidan_mcnay_rr_pick2 u_pick (
        .val0   (req0_istream_val),
        .val1   (req1_istream_val),
        .prio   (r_prio),
        .any    (w_any),
        .winner (w_winner)
    );

    assign w_g_ival = (r_grant_id == REQ1) ? req1_istream_val : req0_istream_val;
    assign w_g_ordy = (r_grant_id == REQ1) ? req1_ostream_rdy : req0_ostream_rdy;

    // Results fan out unqualified; only the grantee's ostream_val marks them live.
    assign req0_result  = div_result;
    assign req1_result  = div_result;
    assign div_dividend = (r_grant_id == REQ1) ? req1_dividend : req0_dividend;
    assign div_divisor  = (r_grant_id == REQ1) ? req1_divisor  : req0_divisor;
    assign grant_id     = r_grant_id;
    assign busy         = (r_state != IDLE);

    always_comb begin
        div_istream_val  = 1'b0;
        div_ostream_rdy  = 1'b0;
        req0_istream_rdy = 1'b0;
        req1_istream_rdy = 1'b0;
        req0_ostream_val = 1'b0;
        req1_ostream_val = 1'b0;
        case (r_state)
            GRANT_REQ: begin
                div_istream_val  = w_g_ival;
                req0_istream_rdy = (r_grant_id == REQ0) & div_istream_rdy;
                req1_istream_rdy = (r_grant_id == REQ1) & div_istream_rdy;
            end
            GRANT_RESP: begin
                div_ostream_rdy  = w_g_ordy;
                req0_ostream_val = (r_grant_id == REQ0) & div_ostream_val;
                req1_ostream_val = (r_grant_id == REQ1) & div_ostream_val;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant_id <= REQ0;
            r_prio     <= REQ0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_winner;
                        r_state    <= GRANT_REQ;
                    end
                end
                GRANT_REQ: begin
                    // A withdrawn request is dropped without touching priority.
                    if (w_g_ival && div_istream_rdy)
                        r_state <= GRANT_RESP;
                    else if (!w_g_ival)
                        r_state <= IDLE;
                end
                GRANT_RESP: begin
                    if (div_ostream_val && w_g_ordy) begin
                        r_state <= IDLE;
                        r_prio  <= ~r_grant_id;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aidan_mcnay_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_aidan_mcnay_div_arbiter
// Brief  : Directed plus random bench against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_aidan_mcnay_div_arbiter;

    localparam int NB = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          v0, v1, ordy0, ordy1, drdy, doval;
    logic [NB-1:0] dvd0, dvs0, dvd1, dvs1, dres;

    logic          irdy0, irdy1, oval0, oval1, div_ival, div_ordy, gid, bsy;
    logic [NB-1:0] res0, res1, div_dvd, div_dvs;

    aidan_mcnay_div_arbiter #(.nbits(NB)) dut (
        .clk              (clk),
        .reset            (reset),
        .req0_istream_val (v0),
        .req0_istream_rdy (irdy0),
        .req0_dividend    (dvd0),
        .req0_divisor     (dvs0),
        .req0_ostream_val (oval0),
        .req0_ostream_rdy (ordy0),
        .req0_result      (res0),
        .req1_istream_val (v1),
        .req1_istream_rdy (irdy1),
        .req1_dividend    (dvd1),
        .req1_divisor     (dvs1),
        .req1_ostream_val (oval1),
        .req1_ostream_rdy (ordy1),
        .req1_result      (res1),
        .div_istream_val  (div_ival),
        .div_istream_rdy  (drdy),
        .div_dividend     (div_dvd),
        .div_divisor      (div_dvs),
        .div_ostream_val  (doval),
        .div_ostream_rdy  (div_ordy),
        .div_result       (dres),
        .grant_id         (gid),
        .busy             (bsy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction-level view: who owns the divider, and whether its request is already accepted.
    int owner    = -1;
    bit accepted = 1'b0;
    bit m_grant  = 1'b0;
    bit m_prio   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit req_phase  = (owner >= 0) && !accepted;
        bit resp_phase = (owner >= 0) && accepted;
        logic gv   = m_grant ? v1 : v0;
        logic gord = m_grant ? ordy1 : ordy0;
        chk("div_istream_val",  div_ival, req_phase ? gv : 1'b0);
        chk("req0_istream_rdy", irdy0, (req_phase && owner == 0) ? drdy : 1'b0);
        chk("req1_istream_rdy", irdy1, (req_phase && owner == 1) ? drdy : 1'b0);
        chk("div_ostream_rdy",  div_ordy, resp_phase ? gord : 1'b0);
        chk("req0_ostream_val", oval0, (resp_phase && owner == 0) ? doval : 1'b0);
        chk("req1_ostream_val", oval1, (resp_phase && owner == 1) ? doval : 1'b0);
        chk("div_dividend",     div_dvd, m_grant ? dvd1 : dvd0);
        chk("div_divisor",      div_dvs, m_grant ? dvs1 : dvs0);
        chk("req0_result",      res0, dres);
        chk("req1_result",      res1, dres);
        chk("grant_id",         gid, m_grant);
        chk("busy",             bsy, owner >= 0);
    endtask

    task automatic update_model();
        logic gv   = m_grant ? v1 : v0;
        logic gord = m_grant ? ordy1 : ordy0;
        if (reset) begin
            owner = -1; accepted = 0; m_grant = 0; m_prio = 0;
        end else if (owner < 0) begin
            if (v0 || v1) begin
                m_grant  = (v0 && v1) ? m_prio : v1;
                owner    = m_grant;
                accepted = 0;
            end
        end else if (!accepted) begin
            if (gv && drdy) accepted = 1;
            else if (!gv)   owner = -1;
        end else if (doval && gord) begin
            owner  = -1;
            m_prio = !m_grant;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a0, input logic a1, input logic r0, input logic r1,
                         input logic dr, input logic dv);
        v0 = a0; v1 = a1; ordy0 = r0; ordy1 = r1; drdy = dr; doval = dv;
    endtask

    task automatic drain();
        drive(0, 0, 1, 1, 1, 1);
        repeat (3) step();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        dvd0 = '0; dvs0 = '0; dvd1 = '0; dvs1 = '0; dres = '0;
        repeat (2) @(posedge clk);
        #1;
        update_model();
        step();
        reset = 1'b0;
        chk("reset_grant_id", gid, 1'b0);
        chk("reset_busy", bsy, 1'b0);

        // Single requester 91/7, result arrives a few cycles after accept.
        dvd0 = 16'd91; dvs0 = 16'd7;
        drive(1, 0, 1, 0, 1, 0);
        step();
        #1 chk("single_irdy_t1", irdy0, 1'b1);
        step();
        drive(0, 0, 1, 0, 1, 0);
        repeat (2) step();
        dres = 16'd13; doval = 1'b1;
        #1 chk("single_oval", oval0, 1'b1);
        chk("single_result", res0, 16'd13);
        chk("single_req1_quiet", oval1, 1'b0);
        step();
        chk("single_idle_after", bsy, 1'b0);
        chk("single_grant_id", gid, 1'b0);
        drive(0, 0, 0, 0, 0, 0);
        step();

        // Ties after a completed req0 transaction: prio is now req1.
        drive(1, 1, 1, 1, 1, 1);
        step();
        chk("tie_first", gid, 1'b1);
        repeat (3) step();
        chk("tie_second", gid, 1'b0);
        repeat (3) step();
        chk("tie_third", gid, 1'b1);
        drain();

        // Result backpressure with the other requester waiting.
        drive(1, 0, 0, 0, 1, 0);
        step();
        chk("bp_grant", gid, 1'b0);
        step();
        drive(0, 1, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_busy", bsy, 1'b1);
            chk("bp_grant_hold", gid, 1'b0);
            chk("bp_div_ordy", div_ordy, 1'b0);
        end
        ordy0 = 1'b1;
        step();
        chk("bp_released", bsy, 1'b0);
        step();
        chk("bp_next_grant", gid, 1'b1);
        drain();

        // Divider stall on the request side.
        dvd0 = 16'd100; dvs0 = 16'd9;
        drive(1, 0, 1, 1, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_irdy", irdy0, 1'b0);
            chk("stall_dividend", div_dvd, 16'd100);
        end
        drdy = 1'b1;
        #1 chk("stall_fire_rdy", irdy0, 1'b1);
        step();
        chk("stall_resp_busy", bsy, 1'b1);
        drain();

        // Reset while waiting on a response, req1 pending across reset.
        drive(1, 0, 0, 0, 1, 0);
        repeat (2) step();
        v0 = 1'b0; v1 = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_grant_id", gid, 1'b0);
        chk("rst_busy", bsy, 1'b0);
        chk("rst_irdy1", irdy1, 1'b0);
        step();
        chk("rst_then_grant1", gid, 1'b1);
        drive(0, 0, 1, 1, 1, 1);
        repeat (2) step();

        // Withdrawal by req0 must leave prio at req0.
        drive(1, 0, 0, 0, 0, 0);
        repeat (2) step();
        v0 = 1'b0;
        step();
        chk("withdraw_idle", bsy, 1'b0);
        drive(1, 1, 0, 0, 0, 0);
        step();
        chk("withdraw_prio_kept", gid, 1'b0);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(63) == 0);
            drive($urandom_range(1), $urandom_range(1), $urandom_range(1),
                  $urandom_range(1), $urandom_range(1), $urandom_range(1));
            dvd0 = NB'($urandom); dvs0 = NB'($urandom);
            dvd1 = NB'($urandom); dvs1 = NB'($urandom);
            dres = NB'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
